// File: rtl/led_bank_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | led_pkg: LED bank field layout and arbiter state encoding        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package led_pkg;

  localparam int LED_W   = 7;
  localparam int LED_RED = 0;
  localparam int LED_GRN = 1;
  localparam int LED_P1  = 2;
  localparam int LED_P2  = 3;
  localparam int LED_P3  = 4;
  localparam int LED_P4  = 5;
  localparam int LED_P5  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/led_bank_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | led_bank_arbiter_if: requester bus plus LED pin bundle           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface led_bank_arbiter_if #(
  parameter int NREQ = 3
);

  logic [NREQ-1:0]                 req;
  logic [led_pkg::LED_W*NREQ-1:0]  pat;
  logic [NREQ-1:0]                 gnt;
  logic                            ledr_n;
  logic                            ledg_n;
  logic                            led1;
  logic                            led2;
  logic                            led3;
  logic                            led4;
  logic                            led5;

  modport master (
    output req, pat,
    input  gnt, ledr_n, ledg_n, led1, led2, led3, led4, led5
  );

  modport slave (
    input  req, pat,
    output gnt, ledr_n, ledg_n, led1, led2, led3, led4, led5
  );

endinterface
`default_nettype wire

// File: rtl/led_bank_arbiter_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin pick, search from last+1   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    winner  = '0;
    index   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int off = 1; off <= N; off++) begin
      w_sum = {1'b0, last} + (IDX_W+1)'(off);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (!w_found && req[w_cand]) begin
        w_found         = 1'b1;
        winner[w_cand]  = 1'b1;
        index           = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_bank_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | led_bank_arbiter: round-robin owner of the LED bank with hold,   |
// | blanking gap and idle heartbeat.            Revision: 1.0        |
// +------------------------------------------------------------------+
module led_bank_arbiter
  import led_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int HOLD_CYCLES = 12000000,
  parameter int HB_DIV      = 6000000
) (
  input  logic               clk,
  input  logic               rst_n,
  led_bank_arbiter_if.slave  bus
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int HB_W   = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

  localparam logic [HOLD_W-1:0] C_HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [HB_W-1:0]   C_HB_LAST  = HB_W'(HB_DIV - 1);
  // Onboard LEDs are active-low; XOR with this maps "on" bits to pin levels.
  localparam logic [LED_W-1:0]  C_ONBOARD_INV = LED_W'((1 << LED_RED) | (1 << LED_GRN));
  localparam logic [LED_W-1:0]  C_PINS_OFF    = C_ONBOARD_INV;

  state_t             r_state;
  logic [NREQ-1:0]    r_gnt;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_last;
  logic [HOLD_W-1:0]  r_hold;
  logic [HB_W-1:0]    r_hb_cnt;
  logic               r_hb;
  logic [LED_W-1:0]   r_pins;

  logic [NREQ-1:0]    w_win;
  logic [IDX_W-1:0]   w_win_idx;
  logic [LED_W-1:0]   w_pat_arr [NREQ];
  logic [LED_W-1:0]   w_pat_own;
  logic [HOLD_W-1:0]  w_hold_inc;
  logic               w_owner_req;
  logic               w_others;

  for (genvar g = 0; g < NREQ; g++) begin : g_pat
    assign w_pat_arr[g] = bus.pat[g*LED_W +: LED_W];
  end

  rr_arbiter #(
    .N     (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req    (bus.req),
    .last   (r_last),
    .winner (w_win),
    .index  (w_win_idx)
  );

  assign w_pat_own   = w_pat_arr[r_owner];
  assign w_owner_req = |(bus.req & r_gnt);
  assign w_others    = |(bus.req & ~r_gnt);
  // The hold test uses the post-increment count, so an owner keeps GNT for
  // exactly HOLD_CYCLES cycles before a waiting requester can preempt it.
  assign w_hold_inc  = (r_hold == C_HOLD_MAX) ? r_hold : r_hold + HOLD_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_owner  <= '0;
      r_last   <= IDX_W'(NREQ - 1);
      r_hold   <= '0;
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
      r_pins   <= C_PINS_OFF;
    end else begin
      if (r_hb_cnt == C_HB_LAST) begin
        r_hb_cnt <= '0;
        r_hb     <= ~r_hb;
      end else begin
        r_hb_cnt <= r_hb_cnt + HB_W'(1);
      end

      case (r_state)
        IDLE: begin
          r_pins <= C_PINS_OFF;
          if (|bus.req) begin
            r_state <= OWN;
            r_gnt   <= w_win;
            r_owner <= w_win_idx;
            r_last  <= w_win_idx;
            r_hold  <= '0;
          end else begin
            r_gnt           <= '0;
            r_pins[LED_GRN] <= ~r_hb;
          end
        end
        OWN: begin
          r_hold <= w_hold_inc;
          if (!w_owner_req || ((w_hold_inc == C_HOLD_MAX) && w_others)) begin
            r_state <= GAP;
            r_gnt   <= '0;
            r_pins  <= C_PINS_OFF;
          end else begin
            r_pins <= w_pat_own ^ C_ONBOARD_INV;
          end
        end
        GAP: begin
          r_state         <= IDLE;
          r_gnt           <= '0;
          r_pins          <= C_PINS_OFF;
          r_pins[LED_GRN] <= ~r_hb;
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_pins  <= C_PINS_OFF;
        end
      endcase
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.ledr_n = r_pins[LED_RED];
  assign bus.ledg_n = r_pins[LED_GRN];
  assign bus.led1   = r_pins[LED_P1];
  assign bus.led2   = r_pins[LED_P2];
  assign bus.led3   = r_pins[LED_P3];
  assign bus.led4   = r_pins[LED_P4];
  assign bus.led5   = r_pins[LED_P5];

endmodule
`default_nettype wire

// File: tb/tb_led_bank_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_led_bank_arbiter: directed vectors with a scoreboard queue    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_led_bank_arbiter;

  localparam int NREQ = 3;
  localparam int HOLD = 4;
  localparam int HBD  = 3;

  localparam logic [9:0] M_ALL  = 10'h3FF;
  localparam logic [9:0] M_IDLE = 10'h3FD;   // heartbeat bit not checked

  // Pin vectors {led5..led1, ledg_n, ledr_n}
  localparam logic [6:0] L_OFF = 7'b0000011;
  localparam logic [6:0] L_P0A = 7'b1010110;  // pat0 = 1010101
  localparam logic [6:0] L_P0B = 7'b0000001;  // pat0 = 0000010
  localparam logic [6:0] L_P1  = 7'b0011111;  // pat1 = 0011100
  localparam logic [6:0] L_P2  = 7'b1100010;  // pat2 = 1100001

  typedef struct {
    logic [9:0] exp;
    logic [9:0] mask;
    int         idx;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_idx = 0;
  exp_t sb [$];
  exp_t push_e;
  exp_t mon_e;
  logic [20:0] pats;
  logic [9:0]  obs;
  logic        hb_seq [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  led_bank_arbiter_if #(.NREQ(NREQ)) bus ();

  led_bank_arbiter #(
    .NREQ        (NREQ),
    .HOLD_CYCLES (HOLD),
    .HB_DIV      (HBD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign obs = {bus.gnt, bus.led5, bus.led4, bus.led3, bus.led2, bus.led1,
                bus.ledg_n, bus.ledr_n};

  function automatic logic [9:0] ex(input logic [2:0] g, input logic [6:0] l);
    return {g, l};
  endfunction

  // Drive inputs for the next rising edge and queue the outputs expected after it.
  task automatic step(input logic r, input logic [2:0] rq, input logic [20:0] pt,
                      input logic [9:0] e, input logic [9:0] m);
    @(negedge clk);
    rst_n   = r;
    bus.req = rq;
    bus.pat = pt;
    push_e.exp  = e;
    push_e.mask = m;
    push_e.idx  = step_idx;
    sb.push_back(push_e);
    step_idx++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 5) begin
      @(posedge clk);
      #2;
      k++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        n_checks++;
        if ((obs & mon_e.mask) !== (mon_e.exp & mon_e.mask)) begin
          n_errors++;
          $display("FAIL step%0d: got gnt=%b pins=%b, want gnt=%b pins=%b (mask %b)",
                   mon_e.idx, obs[9:7], obs[6:0], mon_e.exp[9:7], mon_e.exp[6:0],
                   mon_e.mask);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pats    = {7'b1100001, 7'b0011100, 7'b1010101};
    bus.req = '0;
    bus.pat = pats;

    // Reset held, then free-running heartbeat with nobody requesting
    step(1'b0, 3'b000, pats, ex(3'b000, L_OFF), M_ALL);
    step(1'b0, 3'b000, pats, ex(3'b000, L_OFF), M_ALL);
    for (int i = 0; i < 9; i++)
      step(1'b1, 3'b000, pats, ex(3'b000, {5'b0, hb_seq[i], 1'b1}), M_ALL);

    // Owner 0, live pattern, held 4 cycles then preempted by requester 1
    step(1'b1, 3'b001, pats, ex(3'b001, L_OFF), M_ALL);
    step(1'b1, 3'b001, pats, ex(3'b001, L_P0A), M_ALL);
    step(1'b1, 3'b011, pats, ex(3'b001, L_P0A), M_ALL);
    pats[6:0] = 7'b0000010;
    step(1'b1, 3'b011, pats, ex(3'b001, L_P0B), M_ALL);
    step(1'b1, 3'b011, pats, ex(3'b000, L_OFF), M_ALL);
    step(1'b1, 3'b011, pats, ex(3'b000, L_OFF), M_IDLE);
    step(1'b1, 3'b011, pats, ex(3'b010, L_OFF), M_ALL);

    // Owner 1 drops early while requester 2 waits
    step(1'b1, 3'b110, pats, ex(3'b010, L_P1), M_ALL);
    step(1'b1, 3'b100, pats, ex(3'b000, L_OFF), M_ALL);
    step(1'b1, 3'b100, pats, ex(3'b000, L_OFF), M_IDLE);
    step(1'b1, 3'b100, pats, ex(3'b100, L_OFF), M_ALL);

    // Everybody requesting: 2 -> 0 -> 1 rotation, 4 grant cycles each
    for (int i = 0; i < 3; i++)
      step(1'b1, 3'b111, pats, ex(3'b100, L_P2), M_ALL);
    step(1'b1, 3'b111, pats, ex(3'b000, L_OFF), M_ALL);
    step(1'b1, 3'b111, pats, ex(3'b000, L_OFF), M_IDLE);
    step(1'b1, 3'b111, pats, ex(3'b001, L_OFF), M_ALL);
    for (int i = 0; i < 3; i++)
      step(1'b1, 3'b111, pats, ex(3'b001, L_P0B), M_ALL);
    step(1'b1, 3'b111, pats, ex(3'b000, L_OFF), M_ALL);
    step(1'b1, 3'b111, pats, ex(3'b000, L_OFF), M_IDLE);
    step(1'b1, 3'b111, pats, ex(3'b010, L_OFF), M_ALL);
    step(1'b1, 3'b111, pats, ex(3'b010, L_P1), M_ALL);
    drain();

    // Asynchronous reset while requester 1 owns the bank
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== ex(3'b000, L_OFF)) begin
      n_errors++;
      $display("FAIL async_reset: got gnt=%b pins=%b, want gnt=000 pins=%b",
               obs[9:7], obs[6:0], L_OFF);
    end
    step(1'b0, 3'b111, pats, ex(3'b000, L_OFF), M_ALL);
    step(1'b1, 3'b111, pats, ex(3'b001, L_OFF), M_ALL);
    step(1'b1, 3'b111, pats, ex(3'b001, L_P0B), M_ALL);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_bank_arbiter.md
Name: led_bank_arbiter

Overview:
- Shares the iCEBreaker LED bank between NREQ independent requesters. The bank is the on-board red/green LEDs (active-low) plus PMOD LED1..LED5 (active-high).
- Grants ownership round-robin and enforces a minimum hold time before preemption.
- Inserts a one-cycle blanking gap between owners.
- Drives a green heartbeat when nobody owns the bank.
- Sits directly between application logic and the top-level LED pins.

Parameters:
- NREQ, 3, number of requesters (2..8).
- HOLD_CYCLES, 12000000, minimum cycles an owner keeps the bank before another requester may take it (1 s at 12 MHz); must be >= 1.
- HB_DIV, 6000000, heartbeat half-period in cycles; must be >= 1.

Ports:
- CLK  input  1  system clock (12 MHz).
- RST_N  input  1  reset, asynchronous assert, active-low.
- REQ  input  NREQ  per-requester ownership request, level-held.
- PAT  input  7*NREQ  per-requester pattern. Slice i is bits [7i+6:7i]. Within a slice: bit0 red on, bit1 green on, bits2..6 LED1..LED5 on (all active-high "on").
- GNT  output  NREQ  one-hot grant, or all zero.
- LEDR_N  output  1  red LED, 0 = lit.
- LEDG_N  output  1  green LED, 0 = lit.
- LED1..LED5  output  1 each  PMOD LEDs, 1 = lit.

Behaviour:
- All outputs are registered.
- Reset values: GNT=0, LEDR_N=1, LEDG_N=1, LED1..5=0, state=IDLE, hold counter=0, heartbeat counter=0, hb=0, last_owner=NREQ-1 (so requester 0 wins first).
- Heartbeat:
  - Counter runs freely in every state, 0..HB_DIV-1.
  - hb toggles when the counter wraps at HB_DIV-1.
- State IDLE:
  - GNT=0, LEDR_N=1, LED1..5=0, LEDG_N=~hb.
  - If any REQ bit is set, the round-robin winner is the first set REQ bit searching from last_owner+1 modulo NREQ.
  - On that same edge, GNT is set to the winner, owner=winner, last_owner=winner, hold counter=0, and state goes to OWN. Request-to-grant latency is 1 cycle.
- State OWN:
  - GNT = one-hot owner.
  - LED outputs at edge k+1 reflect PAT[owner] sampled at edge k (1-cycle latency, live tracking).
  - Onboard outputs are inverted; PMOD outputs pass straight through.
  - Hold counter increments, saturating at HOLD_CYCLES.
  - Go to GAP if REQ[owner]=0, at any time regardless of hold.
  - Also go to GAP if hold counter = HOLD_CYCLES and some other REQ bit is set (preemption).
  - Otherwise stay in OWN.
- State GAP:
  - Lasts exactly 1 cycle.
  - GNT=0, LEDR_N=1, LEDG_N=1, LED1..5=0. No heartbeat in GAP.
  - Next state is IDLE, which arbitrates on the following edge. Owner switch therefore costs 2 cycles of no grant.
- Simultaneous events:
  - Owner dropping REQ in the same cycle that hold expires is treated as a drop; the result is identical (GAP).
  - REQ bits that rise during GAP are seen in IDLE.
- REQ deasserted by a non-owner before being granted is simply never served. There is no queueing.
- Reset asserted mid-ownership immediately forces the reset values; no glitch-free requirement applies.
- GNT is never multi-hot. GNT and the lit pattern always refer to the same owner.

Decomposition:
- Package led_pkg holds:
  - LED_W=7
  - bit index constants LED_RED=0, LED_GRN=1, LED_P1..LED_P5=2..6
  - state encoding IDLE/OWN/GAP
- Sub-module rr_arbiter (parameter N): combinational.
  - Inputs: req, last.
  - Outputs: one-hot winner and index.
  - Reusable for other shared board resources.

Test Plan (NREQ=3, HOLD_CYCLES=4, HB_DIV=3):
- Reset, no REQ: LEDG_N toggles every 3 cycles starting 1 after the first wrap; LEDR_N=1; LED1..5=0; GNT=000.
- REQ=001, PAT0=7'b1010101: GNT=001 one cycle later; next cycle LEDR_N=0, LEDG_N=1, LED1=1, LED2=0, LED3=1, LED4=0, LED5=1.
- REQ=011 held: owner 0 is held exactly 4 OWN cycles, then 1 GAP cycle (all off, GNT=000), then 1 IDLE cycle, then GNT=010.
- Owner 1 drops REQ after 2 cycles while REQ[2]=1: GAP immediately with no hold wait; GNT=100 two cycles later.
- REQ=111 continuously: grant order is 0,1,2,0,… and each grant lasts 4 cycles.
- RST_N pulsed low while GNT=010: GNT=000 and LEDs off asynchronously; after release, requester 0 wins first.
